// File: rtl/echo_indication_pkg.sv
// Shared types and header layout for the indication serializer.
// The header word is built at 32 bits; wider data words are zero-extended by the caller.
package echo_indication_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } ser_state_e;

    localparam int unsigned TAG_LSB = 0;
    localparam int unsigned TAG_W   = 16;
    localparam int unsigned LEN_LSB = 16;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned HDR_W   = 32;

    function automatic logic [HDR_W-1:0] build_header(
        input logic [TAG_W-1:0] tag,
        input logic [LEN_W-1:0] len
    );
        logic [HDR_W-1:0] word;
        word                   = '0;
        word[TAG_LSB +: TAG_W] = tag;
        word[LEN_LSB +: LEN_W] = len;
        return word;
    endfunction

endpackage

// File: rtl/indication_msg_fifo.sv
// Synchronous message FIFO with wrap-bit pointers; head is read from the register array.
// Push when full is prevented upstream; pop and push may coincide at any fill level.
module indication_msg_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q[AW-1:0]] <= push_data_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/echo_indication_serializer.sv
// Round-robin arbitration of indication method calls into a message FIFO,
// serialized onto the outbound pipe as a header word followed by argument words.
module echo_indication_serializer
    import echo_indication_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_METHODS = 4,
    parameter int unsigned ARG_WORDS   = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TAG_BASE    = 1
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic [NUM_METHODS-1:0]                  say__ENA,
    input  logic [NUM_METHODS*ARG_WORDS*DATA_WIDTH-1:0] say_args,
    output logic [NUM_METHODS-1:0]                  say__RDY,
    output logic                                    pipe_enq__ENA,
    output logic [DATA_WIDTH-1:0]                   pipe_enq_v,
    output logic                                    pipe_enq_last,
    input  logic                                    pipe_enq__RDY
);

    localparam int unsigned IDXW = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;
    localparam int unsigned ARGB = ARG_WORDS * DATA_WIDTH;
    localparam int unsigned MSGW = IDXW + ARGB;
    localparam int unsigned KW   = $clog2(ARG_WORDS + 1);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [KW-1:0] KLAST = KW'(ARG_WORDS - 1);

    ser_state_e       state_q;
    logic [KW-1:0]    k_q;
    logic [IDXW-1:0]  rr_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [MSGW-1:0]  fifo_head;
    logic [MSGW-1:0]  push_data;

    logic [IDXW-1:0]  win_idx;
    logic             win_vld;
    logic [IDXW-1:0]  idx;
    logic             blocked;

    logic             xfer;
    logic             pop;
    logic             more;
    logic [IDXW-1:0]  head_idx;
    logic [ARGB-1:0]  head_args;
    logic [DATA_WIDTH-1:0] hdr_word;
    logic [DATA_WIDTH-1:0] pay_word;

    // Walk methods in round-robin order; a method is ready until an earlier one requests.
    always_comb begin
        say__RDY = '0;
        win_vld  = 1'b0;
        win_idx  = '0;
        blocked  = 1'b0;
        idx      = '0;
        if (!RST && !fifo_full) begin
            for (int unsigned off = 0; off < NUM_METHODS; off++) begin
                idx           = IDXW'((32'(rr_q) + off) % NUM_METHODS);
                say__RDY[idx] = !blocked;
                if (say__ENA[idx] && !blocked) begin
                    win_vld = 1'b1;
                    win_idx = idx;
                end
                blocked = blocked | say__ENA[idx];
            end
        end
    end

    assign push_data = {win_idx, say_args[32'(win_idx)*ARGB +: ARGB]};

    indication_msg_fifo #(
        .WIDTH (MSGW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .rst         (RST),
        .push_i      (win_vld),
        .push_data_i (push_data),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign head_idx  = fifo_head[MSGW-1 -: IDXW];
    assign head_args = fifo_head[ARGB-1:0];
    assign hdr_word  = DATA_WIDTH'(build_header(TAG_W'(TAG_BASE + 32'(head_idx)),
                                                LEN_W'(ARG_WORDS + 1)));
    assign pay_word  = head_args[32'(k_q)*DATA_WIDTH +: DATA_WIDTH];

    assign xfer          = (state_q != IDLE) && pipe_enq__RDY && !RST;
    assign pop           = xfer && (state_q == PAYLOAD) && (k_q == KLAST);
    assign more          = (fifo_count > CW'(1)) || win_vld;
    assign pipe_enq__ENA = xfer;

    always_comb begin
        pipe_enq_v    = '0;
        pipe_enq_last = 1'b0;
        case (state_q)
            HEADER:  pipe_enq_v = hdr_word;
            PAYLOAD: begin
                pipe_enq_v    = pay_word;
                pipe_enq_last = (k_q == KLAST);
            end
            default: ;
        endcase
    end

    // Leaving IDLE on the push itself gives a header the cycle after acceptance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            k_q     <= '0;
            rr_q    <= '0;
        end else begin
            if (win_vld) begin
                rr_q <= IDXW'((32'(win_idx) + 1) % NUM_METHODS);
            end
            case (state_q)
                IDLE: begin
                    if (!fifo_empty || win_vld) state_q <= HEADER;
                end
                HEADER: begin
                    if (xfer) begin
                        state_q <= PAYLOAD;
                        k_q     <= '0;
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        if (k_q == KLAST) begin
                            k_q     <= '0;
                            state_q <= more ? HEADER : IDLE;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_indication_serializer.sv
// Directed and randomized checks of the indication serializer against a queue-based
// reference model of accepted messages and expected outbound words.
module tb_echo_indication_serializer;

    localparam int DW = 32;
    localparam int NM = 4;
    localparam int AW = 2;
    localparam int FD = 4;
    localparam int TB = 1;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NM-1:0]        ena;
    logic [NM*AW*DW-1:0]  args;
    logic [NM-1:0]        rdy;
    logic                 penq_ena;
    logic [DW-1:0]        pv;
    logic                 plast;
    logic                 prdy;

    always #5 CLK = ~CLK;

    echo_indication_serializer #(
        .DATA_WIDTH  (DW),
        .NUM_METHODS (NM),
        .ARG_WORDS   (AW),
        .FIFO_DEPTH  (FD),
        .TAG_BASE    (TB)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .say__ENA      (ena),
        .say_args      (args),
        .say__RDY      (rdy),
        .pipe_enq__ENA (penq_ena),
        .pipe_enq_v    (pv),
        .pipe_enq_last (plast),
        .pipe_enq__RDY (prdy)
    );

    typedef struct {
        logic [DW-1:0] w;
        bit            last;
    } word_t;

    word_t wq[$];
    int    cnt;
    int    rr;
    int    tests;
    int    fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_arg(input int m, input int k, input logic [DW-1:0] v);
        args[(m*AW+k)*DW +: DW] = v;
    endtask

    task automatic rand_args();
        for (int m = 0; m < NM; m++)
            for (int k = 0; k < AW; k++)
                set_arg(m, k, $urandom);
    endtask

    // Distance of the first requester from rr decides who may proceed this cycle.
    task automatic predict(output logic [NM-1:0] er, output int win);
        int first;
        first = NM;
        win   = -1;
        er    = '0;
        if (!RST && cnt < FD) begin
            for (int d = NM - 1; d >= 0; d--)
                if (ena[(rr + d) % NM]) first = d;
            for (int i = 0; i < NM; i++)
                er[i] = (((i - rr + NM) % NM) <= first);
            if (first < NM) win = (rr + first) % NM;
        end
    endtask

    // Check current outputs, then advance one clock and update the model.
    task automatic cyc();
        logic [NM-1:0] er;
        int            win;
        bit            exp_x;
        #1;
        predict(er, win);
        chk("say_rdy", rdy, er);
        exp_x = !RST && (wq.size() > 0) && prdy;
        chk("enq_ena", penq_ena, exp_x);
        if (!RST) begin
            if (wq.size() > 0) begin
                chk("enq_v", pv, wq[0].w);
                if (exp_x) chk("enq_last", plast, wq[0].last);
            end else begin
                chk("idle_v", pv, 0);
                chk("idle_last", plast, 0);
            end
        end
        @(posedge CLK);
        if (RST) begin
            wq.delete();
            cnt = 0;
            rr  = 0;
        end else begin
            if (exp_x) begin
                if (wq[0].last) cnt--;
                void'(wq.pop_front());
            end
            if (win >= 0) begin
                word_t e;
                e.w    = ((AW + 1) << 16) | (TB + win);
                e.last = 0;
                wq.push_back(e);
                for (int k = 0; k < AW; k++) begin
                    e.w    = args[(win*AW+k)*DW +: DW];
                    e.last = (k == AW - 1);
                    wq.push_back(e);
                end
                cnt++;
                rr = (win + 1) % NM;
            end
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cnt   = 0;
        rr    = 0;
        RST   = 1'b1;
        ena   = '0;
        args  = '0;
        prdy  = 1'b1;
        @(negedge CLK);
        cyc();
        cyc();
        RST = 1'b0;
        #1;
        chk("rst_rdy", rdy, 4'hF);
        chk("rst_ena", penq_ena, 0);
        chk("rst_v", pv, 0);
        chk("rst_last", plast, 0);
        cyc();

        // Single call on method 2
        set_arg(2, 0, 32'hA);
        set_arg(2, 1, 32'hB);
        ena = 4'b0100;
        cyc();
        ena = '0;
        #1 chk("single_hdr", pv, 32'h0003_0003);
        chk("single_hdr_ena", penq_ena, 1);
        cyc();
        #1 chk("single_a", pv, 32'hA);
        cyc();
        #1 chk("single_b", pv, 32'hB);
        chk("single_last", plast, 1);
        cyc();
        #1 chk("single_idle", penq_ena, 0);
        cyc();

        // Contention from a fresh round-robin pointer
        do_reset();
        rand_args();
        ena = '1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("one_hot_rdy", $countones(rdy), 1);
            cyc();
        end
        ena = '0;
        repeat (20) cyc();

        // Back-pressure with pipe ready pattern 1,0,0
        for (int i = 0; i < 60; i++) begin
            prdy = (i % 3 == 0);
            ena  = (i < 30) ? NM'($urandom & $urandom) : '0;
            rand_args();
            cyc();
        end
        prdy = 1'b1;
        ena  = '0;
        repeat (30) cyc();

        // Full buffer, pop one, refill
        do_reset();
        prdy = 1'b0;
        ena  = 4'b0001;
        repeat (4) begin
            rand_args();
            cyc();
        end
        #1 chk("full_rdy", rdy, 0);
        cyc();
        ena  = '0;
        prdy = 1'b1;
        repeat (3) cyc();
        prdy = 1'b0;
        #1 chk("reopen_rdy", rdy, 4'hF);
        ena = 4'b0001;
        rand_args();
        cyc();
        ena = '0;
        #1 chk("refull_rdy", rdy, 0);
        cyc();
        prdy = 1'b1;
        repeat (16) cyc();

        // Reset in the middle of a message with three more buffered
        do_reset();
        prdy = 1'b0;
        ena  = 4'b0001;
        repeat (4) begin
            rand_args();
            cyc();
        end
        ena  = '0;
        prdy = 1'b1;
        cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        repeat (3) begin
            #1 chk("post_rst_quiet", penq_ena, 0);
            cyc();
        end
        rand_args();
        ena = 4'b0010;
        cyc();
        ena = '0;
        #1 chk("rst_new_hdr", pv, 32'h0003_0002);
        cyc();
        repeat (4) cyc();

        // Arguments captured at acceptance
        set_arg(0, 0, 32'h1111_1111);
        set_arg(0, 1, 32'h2222_2222);
        ena = 4'b0001;
        cyc();
        ena = '0;
        rand_args();
        cyc();
        #1 chk("cap_a", pv, 32'h1111_1111);
        rand_args();
        cyc();
        #1 chk("cap_b", pv, 32'h2222_2222);
        cyc();
        repeat (2) cyc();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            RST  = ($urandom_range(99) == 0);
            ena  = NM'($urandom & $urandom);
            prdy = ($urandom_range(3) != 0);
            rand_args();
            cyc();
        end
        RST  = 1'b0;
        ena  = '0;
        prdy = 1'b1;
        repeat (40) cyc();
        #1 chk("drained_ena", penq_ena, 0);
        chk("drained_rdy", rdy, 4'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
